// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000-style bus initiator and its responders:
// bus widths, byte-enable encodings, timeout default and the initiator state set.
package m68k_bus_pkg;

  localparam int ADDR_W          = 23;
  localparam int DATA_W          = 16;
  localparam int DEFAULT_TIMEOUT = 64;

  localparam logic [1:0] BE_NONE  = 2'b00;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_WORD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STRB,
    ST_WAIT,
    ST_DATA,
    ST_DONE
  } bus_state_t;

endpackage

// File: rtl/m68k_bus_initiator.sv
// 68000-style asynchronous bus master: one local request becomes one AS/DS strobed
// bus cycle terminated by DTACKn, or by a timeout when nothing answers.
//
// state | meaning
// IDLE  | waiting for a request; ready only while DTACKn is high
// ADDR  | address/RW driven; next edge asserts AS (and DS for reads)
// STRB  | AS asserted; next edge asserts DS for writes, clears timeout counter
// WAIT  | sampling DTACKn each edge, counting toward the timeout
// DATA  | DTACK seen; next edge captures read data and negates strobes
// DONE  | rsp_valid high for one clock; D_oe/RWn released on exit
module m68k_bus_initiator
  import m68k_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic              CLKCPU,
  input  logic              RESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D_out,
  output logic              D_oe,
  input  logic [DATA_W-1:0] D_in,
  output logic              ASn,
  output logic              UDSn,
  output logic              LDSn,
  output logic              RWn,
  input  logic              DTACKn
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  bus_state_t        state, state_nx;
  logic [7:0]        cnt, cnt_nx;
  logic [1:0]        be_q, be_nx;
  logic [ADDR_W-1:0] a_nx;
  logic [DATA_W-1:0] dout_nx, rdata_nx;
  logic              doe_nx, asn_nx, udsn_nx, ldsn_nx, rwn_nx;
  logic              rv_nx, to_nx;

  // A stretched DTACK from the previous slave must not leak into the next cycle.
  assign req_ready = (state == ST_IDLE) && DTACKn;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    be_nx    = be_q;
    a_nx     = A;
    dout_nx  = D_out;
    doe_nx   = D_oe;
    asn_nx   = ASn;
    udsn_nx  = UDSn;
    ldsn_nx  = LDSn;
    rwn_nx   = RWn;
    rdata_nx = rsp_rdata;
    rv_nx    = 1'b0;
    to_nx    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          a_nx     = req_addr;
          rwn_nx   = req_rw;
          be_nx    = req_be;
          dout_nx  = req_rw ? '0 : req_wdata;
          state_nx = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (be_q == BE_NONE) begin
          // Empty access: no bus strobes, respond immediately.
          rv_nx    = 1'b1;
          rdata_nx = '0;
          state_nx = ST_DONE;
        end else begin
          asn_nx = 1'b0;
          if (RWn) begin
            udsn_nx = ~|(be_q & BE_UPPER);
            ldsn_nx = ~|(be_q & BE_LOWER);
          end else begin
            doe_nx = 1'b1;
          end
          state_nx = ST_STRB;
        end
      end
      ST_STRB: begin
        if (!RWn) begin
          udsn_nx = ~|(be_q & BE_UPPER);
          ldsn_nx = ~|(be_q & BE_LOWER);
        end
        cnt_nx   = 8'd0;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (!DTACKn) begin
          state_nx = ST_DATA;
        end else begin
          cnt_nx = cnt + 8'd1;
          if (cnt == CNT_LAST) begin
            asn_nx   = 1'b1;
            udsn_nx  = 1'b1;
            ldsn_nx  = 1'b1;
            rv_nx    = 1'b1;
            to_nx    = 1'b1;
            rdata_nx = '0;
            state_nx = ST_DONE;
          end
        end
      end
      ST_DATA: begin
        rdata_nx = RWn ? D_in : '0;
        asn_nx   = 1'b1;
        udsn_nx  = 1'b1;
        ldsn_nx  = 1'b1;
        rv_nx    = 1'b1;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        doe_nx   = 1'b0;
        rwn_nx   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLKCPU) begin
    if (!RESETn) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      be_q        <= BE_NONE;
      A           <= '0;
      D_out       <= '0;
      D_oe        <= 1'b0;
      ASn         <= 1'b1;
      UDSn        <= 1'b1;
      LDSn        <= 1'b1;
      RWn         <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      be_q        <= be_nx;
      A           <= a_nx;
      D_out       <= dout_nx;
      D_oe        <= doe_nx;
      ASn         <= asn_nx;
      UDSn        <= udsn_nx;
      LDSn        <= ldsn_nx;
      RWn         <= rwn_nx;
      rsp_valid   <= rv_nx;
      rsp_timeout <= to_nx;
      rsp_rdata   <= rdata_nx;
    end
  end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Self-checking bench for m68k_bus_initiator: directed and random bus cycles with a
// scripted DTACK responder, checked cycle by cycle against a transaction-timing model.
module tb_m68k_bus_initiator;
  import m68k_bus_pkg::*;

  localparam int T = 8;

  logic              CLKCPU = 1'b0;
  logic              RESETn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_rw = 1'b1;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [1:0]        req_be = BE_NONE;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D_out;
  logic              D_oe;
  logic [DATA_W-1:0] D_in = '0;
  logic              ASn, UDSn, LDSn, RWn;
  logic              DTACKn = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  m68k_bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .CLKCPU(CLKCPU), .RESETn(RESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RWn(RWn), .DTACKn(DTACKn)
  );

  always #5 CLKCPU = ~CLKCPU;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Edge (counted from the accept edge) on which rsp_valid becomes visible.
  function automatic int exp_lat(input logic [1:0] be, input int k);
    if (be == BE_NONE) return 1;
    if (k >= 0 && k <= T - 1) return 4 + k;
    return 2 + T;
  endfunction

  // k: DTACKn sampled low on the k-th WAIT edge (edge 3+k after accept), -1 = never.
  // h: extra edges DTACKn stays low after AS negates.
  task automatic run_txn(input logic rw, input logic [ADDR_W-1:0] addr, input logic [1:0] be,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] din,
                         input int k, input int h, input logic hold_valid);
    int lat, n, g;
    logic exp_to, bus_act, ds_act, dt_low, exp_rdy, done;
    logic [DATA_W-1:0] exp_rd;
    logic [4:0] exp_bus;
    logic [31:0] r;
    lat    = exp_lat(be, k);
    exp_to = (be != BE_NONE) && (k < 0);
    exp_rd = (be == BE_NONE || exp_to || !rw) ? 16'h0 : din;
    req_rw = rw; req_addr = addr; req_be = be; req_wdata = wdata; D_in = din;
    req_valid = 1'b1; DTACKn = 1'b1;
    g = 0;
    while (!req_ready && g < 50) begin
      @(posedge CLKCPU); #2; g++;
    end
    chk("ready_idle", 32'(req_ready), 32'd1);
    @(posedge CLKCPU);
    n = 0; done = 1'b0;
    while (!done) begin
      #1;
      r = $urandom;
      req_valid = hold_valid; req_rw = r[31]; req_be = r[30:29];
      req_addr = r[22:0]; req_wdata = r[15:0];
      bus_act = (be != BE_NONE) && n >= 1 && n <= lat - 1;
      ds_act  = rw ? bus_act : ((be != BE_NONE) && n >= 2 && n <= lat - 1);
      exp_bus = {!bus_act, !(ds_act && be[1]), !(ds_act && be[0]),
                 (n <= lat) ? rw : 1'b1,
                 !rw && (be != BE_NONE) && n >= 1 && n <= lat};
      chk("bus_ctl", 32'({ASn, UDSn, LDSn, RWn, D_oe}), 32'(exp_bus));
      if (n <= lat) begin
        chk("addr", 32'(A), 32'(addr));
        if (!rw) chk("d_out", 32'(D_out), 32'(wdata));
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(n == lat));
      if (n == lat) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
      end
      dt_low  = (k >= 0) && (n + 1 >= 3 + k) && (n + 1 <= 4 + k + h);
      DTACKn  = !dt_low;
      exp_rdy = (n >= lat + 1) && !dt_low;
      #1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_rdy) done = 1'b1;
      else if (n >= 200) begin
        chk("loop_bound", 32'd0, 32'd1);
        done = 1'b1;
      end else begin
        @(posedge CLKCPU);
        n++;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic reset_in_wait();
    req_rw = 1'b1; req_addr = 23'h012345; req_be = BE_WORD; DTACKn = 1'b1;
    req_valid = 1'b1;
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(posedge CLKCPU); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge CLKCPU);
    #1;
    chk("rst_pre_as", 32'(ASn), 32'd0);
    RESETn = 1'b0;
    @(posedge CLKCPU); #1;
    chk("rst_bus", 32'({ASn, UDSn, LDSn, RWn, D_oe}), 32'b11110);
    chk("rst_addr", 32'(A), 32'd0);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    @(posedge CLKCPU); #1;
    RESETn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge CLKCPU); #1;
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    #1;
  endtask

  initial begin
    logic [31:0] r;
    int k;
    RESETn = 1'b0;
    repeat (3) @(posedge CLKCPU);
    #1;
    chk("reset_bus", 32'({ASn, UDSn, LDSn, RWn, D_oe}), 32'b11110);
    chk("reset_addr", 32'(A), 32'd0);
    chk("reset_dout", 32'(D_out), 32'd0);
    chk("reset_rsp", 32'({rsp_valid, rsp_timeout}), 32'd0);
    chk("reset_rdata", 32'(rsp_rdata), 32'd0);
    RESETn = 1'b1;
    @(posedge CLKCPU); #2;

    run_txn(1'b1, 23'h100000, BE_WORD,  16'h0000, 16'hA55A, 0,     0, 1'b0);
    run_txn(1'b0, 23'h770000, BE_LOWER, 16'h00C3, 16'h1234, 4,     0, 1'b0);
    run_txn(1'b1, 23'h600000, BE_WORD,  16'h0000, 16'hBEEF, -1,    0, 1'b0);
    run_txn(1'b1, 23'h600001, BE_UPPER, 16'h0000, 16'h5AA5, T - 1, 0, 1'b0);
    run_txn(1'b1, 23'h000010, BE_WORD,  16'h0000, 16'h0F0F, 0,     3, 1'b1);
    run_txn(1'b0, 23'h000020, BE_WORD,  16'h8001, 16'h7777, 1,     0, 1'b0);
    run_txn(1'b1, 23'h000030, BE_NONE,  16'h0000, 16'hFFFF, 0,     0, 1'b0);
    run_txn(1'b0, 23'h000031, BE_NONE,  16'h4321, 16'hFFFF, -1,    0, 1'b1);
    reset_in_wait();
    run_txn(1'b1, 23'h2AAAAA, BE_WORD,  16'h0000, 16'hC0DE, 2,     1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      k = int'($urandom_range(0, T)) - 1;
      run_txn(r[31], r[22:0], r[30:29], r[15:0], r[28:13] ^ 16'h5A5A, k,
              int'($urandom_range(0, 3)), r[24]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
